// File: rtl/aes_pkg.sv
// aes_pkg: shared AES-256 constants, FSM state type and round helpers
//   NR/NB/NK/KW  round count, columns, key words, expanded-key width
//   state_t      IDLE / ROUND / DONE
//   round_key()  128-bit round key r out of the packed expanded key
//   xtime()      multiply by x in GF(2^8), polynomial 0x11B
package aes_pkg;
   localparam int NR = 14;
   localparam int NB = 4;
   localparam int NK = 8;
   localparam int KW = 128 * (NR + 1);
   typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;
   function automatic logic [127:0] round_key(input logic [KW-1:0] k, input logic [3:0] r);
      return k[KW-1-128*r -: 128];
   endfunction
   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction
endpackage

// File: rtl/aes_sbox.sv
// aes_sbox: combinational AES forward S-box
//   din   byte to substitute
//   dout  substituted byte
module aes_sbox (
   input  logic [7:0] din,
   output logic [7:0] dout
);
   localparam logic [2047:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };
   assign dout = SBOX[2047-8*din -: 8];
endmodule

// File: rtl/aes256_enc_iter.sv
// aes256_enc_iter: iterative AES-256 encryptor, one round per clock
//   in_valid/in_ready/data_in     plaintext handshake (accept only in IDLE)
//   exp_key                       expanded key, round key r at [KW-1-128*r -: 128]
//   out_valid/out_ready/data_out  ciphertext handshake (held in DONE)
//   busy                          high in ROUND and DONE
//   AES_KEY_LATCH_EN              when defined, exp_key is captured on accept
module aes256_enc_iter #(
   parameter int NR = 14,
   parameter int KW = 1920
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [127:0]  data_in,
   input  logic [KW-1:0] exp_key,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [127:0]  data_out,
   output logic          busy
);
   import aes_pkg::state_t;
   import aes_pkg::IDLE;
   import aes_pkg::ROUND;
   import aes_pkg::DONE;
   import aes_pkg::round_key;
   import aes_pkg::xtime;
   localparam logic [3:0] last = 4'(NR);
   state_t st, st_nx;
   logic [3:0] rnd;
   logic [127:0] s, sb, sr, mc, nxt;
   logic [KW-1:0] key_src;
   logic accept;
   assign accept = in_valid & in_ready;
`ifdef AES_KEY_LATCH_EN
   logic [KW-1:0] key_q;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) key_q <= '0;
      else if (accept) key_q <= exp_key;
   assign key_src = key_q;
`else
   assign key_src = exp_key;
`endif
   // byte i sits at row i%4, column i/4; ShiftRows pulls row r left by r columns
   for (genvar i = 0; i < 16; i++) begin : g_byte
      localparam int row = i % 4;
      localparam int col = i / 4;
      localparam int sh = row + 4 * ((col + row) % 4);
      localparam int b1 = 4 * col + (row + 1) % 4;
      localparam int b2 = 4 * col + (row + 2) % 4;
      localparam int b3 = 4 * col + (row + 3) % 4;
      aes_sbox u_sbox (.din(s[127-8*i -: 8]), .dout(sb[127-8*i -: 8]));
      assign sr[127-8*i -: 8] = sb[127-8*sh -: 8];
      // 2*a_k ^ 3*a_{k+1} ^ a_{k+2} ^ a_{k+3}, folded into one xtime
      assign mc[127-8*i -: 8] = xtime(sr[127-8*i -: 8] ^ sr[127-8*b1 -: 8])
                              ^ sr[127-8*b1 -: 8] ^ sr[127-8*b2 -: 8] ^ sr[127-8*b3 -: 8];
   end
   assign nxt = ((rnd == last) ? sr : mc) ^ round_key(key_src, rnd);
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) st <= IDLE;
      else st <= st_nx;
   always_comb begin
      st_nx = (st == IDLE)  ? (in_valid ? ROUND : IDLE) :
              (st == ROUND) ? ((rnd == last) ? DONE : ROUND) :
                              (out_ready ? IDLE : DONE);
   end
   always_comb begin
      in_ready = (st == IDLE);
      out_valid = (st == DONE);
      busy = (st != IDLE);
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         s <= '0;
         rnd <= '0;
         data_out <= '0;
      end else if (accept) begin
         s <= data_in ^ round_key(exp_key, 4'd0);
         rnd <= 4'd1;
      end else if (st == ROUND) begin
         s <= nxt;
         rnd <= (rnd == last) ? 4'd0 : rnd + 4'd1;
         if (rnd == last) data_out <= nxt;
      end
endmodule
